preg_alloc_pool: RTL and testbench

Physical-register free pool: the responder side of the rename-stage allocation handshake. It holds every unmapped physical register index in a circular FIFO and presents the next two free indices to the decode/rename stage. It consumes 0–2 allocations per cycle and accepts 0–2 frees per cycle from retire. It checkpoints its head pointer per speculative branch tag so that a branch shootdown reclaims every register allocated on the squashed path in one cycle.

---
 rtl/preg_alloc_pool.sv | 120 ++++++++++++
 tb/tb_preg_alloc_pool.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/preg_alloc_pool.sv
// Physical-register free pool: circular FIFO of unmapped preg indices with
// per-branch-tag head checkpoints for single-cycle squash recovery.
module preg_alloc_pool #(
    parameter int unsigned NUM_PREGS              = 64,
    parameter int unsigned NUM_AREGS              = 32,
    parameter int unsigned MAX_PREDICT_DEPTH_BITS = 2,
    localparam int unsigned PW = $clog2(NUM_PREGS),
    localparam int unsigned TW = MAX_PREDICT_DEPTH_BITS
) (
    input  logic          clk,
    input  logic          reset,
    output logic [PW-1:0] preg1,
    output logic [PW-1:0] preg2,
    output logic [PW:0]   num_free,
    input  logic [1:0]    alloc_cnt,
    input  logic          ckpt_en,
    input  logic [TW-1:0] ckpt_tag,
    input  logic          branch_shootdown,
    input  logic [TW-1:0] shootdown_tag,
    input  logic [1:0]    free_en,
    input  logic [PW-1:0] free_preg1,
    input  logic [PW-1:0] free_preg2,
    output logic          alloc_err,
    output logic          free_err
);

    localparam int unsigned NCKPT = 1 << TW;
    localparam int unsigned NINIT = NUM_PREGS - NUM_AREGS;

    logic [PW-1:0] fifo [NUM_PREGS];
    logic [PW:0]   ckpt [NCKPT];
    logic [PW:0]   head;
    logic [PW:0]   tail;
    logic [PW:0]   head_alloc;
    logic [PW:0]   head_nxt;
    logic [PW:0]   tail_nxt;
    logic [PW:0]   alloc_amt;
    logic [PW:0]   free_amt;
    logic [PW+1:0] free_total;
    logic          alloc_ok;
    logic          free_ok;
    logic [PW-1:0] head_idx_p1;
    logic [PW-1:0] tail_idx;
    logic [PW-1:0] tail_idx_p1;

    // Index arithmetic uses only the low bits; the wrap bit matters for counts only.
    assign head_idx_p1 = head[PW-1:0] + PW'(1);
    assign tail_idx    = tail[PW-1:0];
    assign tail_idx_p1 = tail[PW-1:0] + PW'(1);

    // Zero-latency presentation of the next two free indices.
    assign preg1 = fifo[head[PW-1:0]];
    assign preg2 = fifo[head_idx_p1];

    // Legality checks and next-pointer computation; both checks use registered num_free.
    always_comb begin
        alloc_amt  = (PW+1)'(alloc_cnt);
        free_amt   = (PW+1)'(free_en[0]) + (PW+1)'(free_en[1]);
        free_total = (PW+2)'(num_free) + (PW+2)'(free_amt);
        alloc_ok   = (alloc_cnt != 2'd3) && (alloc_amt <= num_free);
        free_ok    = free_total <= (PW+2)'(NUM_PREGS);

        head_alloc = head;
        if (alloc_ok) begin
            head_alloc = head + alloc_amt;
        end

        head_nxt = head_alloc;
        if (branch_shootdown) begin
            head_nxt = ckpt[shootdown_tag];
        end

        tail_nxt = tail;
        if (free_ok) begin
            tail_nxt = tail + free_amt;
        end
    end

    // Pointer, checkpoint, free-list and error-pulse state.
    always_ff @(posedge clk) begin
        if (reset) begin
            head      <= '0;
            tail      <= (PW+1)'(NINIT);
            num_free  <= (PW+1)'(NINIT);
            alloc_err <= 1'b0;
            free_err  <= 1'b0;
            for (int unsigned i = 0; i < NUM_PREGS; i++) begin
                fifo[i] <= (i < NINIT) ? PW'(NUM_AREGS + i) : '0;
            end
            for (int unsigned j = 0; j < NCKPT; j++) begin
                ckpt[j] <= '0;
            end
        end else begin
            head      <= head_nxt;
            tail      <= tail_nxt;
            num_free  <= tail_nxt - head_nxt;
            alloc_err <= !alloc_ok;
            free_err  <= !free_ok;

            // A shootdown discards a same-cycle checkpoint request.
            if (ckpt_en && !branch_shootdown) begin
                ckpt[ckpt_tag] <= head_alloc;
            end

            // Compact valid frees into consecutive tail slots.
            if (free_ok) begin
                case (free_en)
                    2'b01: fifo[tail_idx] <= free_preg1;
                    2'b10: fifo[tail_idx] <= free_preg2;
                    2'b11: begin
                        fifo[tail_idx]    <= free_preg1;
                        fifo[tail_idx_p1] <= free_preg2;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_preg_alloc_pool.sv
// Self-checking bench for preg_alloc_pool: vector table plus wrap and overflow sequences.
module tb_preg_alloc_pool;

    localparam int unsigned NUM_PREGS = 64;
    localparam int unsigned NUM_AREGS = 32;
    localparam int unsigned TB_PW     = 6;
    localparam int unsigned TB_TW     = 2;

    logic               clk;
    logic               reset;
    logic [TB_PW-1:0]   preg1;
    logic [TB_PW-1:0]   preg2;
    logic [TB_PW:0]     num_free;
    logic [1:0]         alloc_cnt;
    logic               ckpt_en;
    logic [TB_TW-1:0]   ckpt_tag;
    logic               branch_shootdown;
    logic [TB_TW-1:0]   shootdown_tag;
    logic [1:0]         free_en;
    logic [TB_PW-1:0]   free_preg1;
    logic [TB_PW-1:0]   free_preg2;
    logic               alloc_err;
    logic               free_err;

    preg_alloc_pool #(
        .NUM_PREGS(NUM_PREGS),
        .NUM_AREGS(NUM_AREGS),
        .MAX_PREDICT_DEPTH_BITS(TB_TW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .preg1(preg1),
        .preg2(preg2),
        .num_free(num_free),
        .alloc_cnt(alloc_cnt),
        .ckpt_en(ckpt_en),
        .ckpt_tag(ckpt_tag),
        .branch_shootdown(branch_shootdown),
        .shootdown_tag(shootdown_tag),
        .free_en(free_en),
        .free_preg1(free_preg1),
        .free_preg2(free_preg2),
        .alloc_err(alloc_err),
        .free_err(free_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string name;
        bit    rst;
        int    alloc;
        bit    ce;
        int    ct;
        bit    sd;
        int    st;
        int    fe;
        int    f1;
        int    f2;
        int    nf;
        int    p1;
        int    p2;
        bit    aerr;
        bit    ferr;
    } vec_t;

    typedef struct {
        string name;
        int    nf;
        int    p1;
        int    p2;
        bit    aerr;
        bit    ferr;
    } exp_t;

    int   errors = 0;
    int   checks = 0;
    exp_t sbq[$];
    vec_t vecs[$];

    function automatic vec_t mk(string name, bit rst, int alloc, bit ce, int ct,
                                bit sd, int st, int fe, int f1, int f2,
                                int nf, int p1, int p2, bit aerr, bit ferr);
        vec_t v;
        v.name = name; v.rst = rst; v.alloc = alloc; v.ce = ce; v.ct = ct;
        v.sd = sd; v.st = st; v.fe = fe; v.f1 = f1; v.f2 = f2;
        v.nf = nf; v.p1 = p1; v.p2 = p2; v.aerr = aerr; v.ferr = ferr;
        return v;
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle, queue its expectation, then compare after the edge.
    task automatic step(input vec_t v);
        exp_t e;
        exp_t got;
        reset            = v.rst;
        alloc_cnt        = 2'(v.alloc);
        ckpt_en          = v.ce;
        ckpt_tag         = TB_TW'(v.ct);
        branch_shootdown = v.sd;
        shootdown_tag    = TB_TW'(v.st);
        free_en          = 2'(v.fe);
        free_preg1       = TB_PW'(v.f1);
        free_preg2       = TB_PW'(v.f2);
        e.name = v.name; e.nf = v.nf; e.p1 = v.p1; e.p2 = v.p2;
        e.aerr = v.aerr; e.ferr = v.ferr;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        got = sbq.pop_front();
        check({got.name, ".num_free"}, int'(num_free), got.nf);
        if (got.nf >= 1) check({got.name, ".preg1"}, int'(preg1), got.p1);
        if (got.nf >= 2) check({got.name, ".preg2"}, int'(preg2), got.p2);
        check({got.name, ".alloc_err"}, int'(alloc_err), int'(got.aerr));
        check({got.name, ".free_err"}, int'(free_err), int'(got.ferr));
    endtask

    task automatic do_reset(string name);
        step(mk(name, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32, 32, 33, 0, 0));
    endtask

    initial begin
        int mq[$];
        int inuse[$];
        int a1, a2, r1, r2;

        reset = 1'b1; alloc_cnt = '0; ckpt_en = 1'b0; ckpt_tag = '0;
        branch_shootdown = 1'b0; shootdown_tag = '0; free_en = '0;
        free_preg1 = '0; free_preg2 = '0;

        // Vector table: alloc/drain/error/free, then checkpoint and shootdown.
        vecs.push_back(mk("rst0",      1, 0, 0, 0, 0, 0, 0, 0, 0, 32, 32, 33, 0, 0));
        vecs.push_back(mk("idle",      0, 0, 0, 0, 0, 0, 0, 0, 0, 32, 32, 33, 0, 0));
        vecs.push_back(mk("alloc2",    0, 2, 0, 0, 0, 0, 0, 0, 0, 30, 34, 35, 0, 0));
        for (int k = 0; k < 15; k++)
            vecs.push_back(mk("drain", 0, 2, 0, 0, 0, 0, 0, 0, 0, 28 - 2*k, 36 + 2*k, 37 + 2*k, 0, 0));
        vecs.push_back(mk("empty_a1",  0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk("free11",    0, 0, 0, 0, 0, 0, 3, 5, 9, 2, 5, 9, 0, 0));
        vecs.push_back(mk("alloc3",    0, 3, 0, 0, 0, 0, 0, 0, 0, 2, 5, 9, 1, 0));
        vecs.push_back(mk("a2_free01", 0, 2, 0, 0, 0, 0, 1, 7, 0, 1, 7, 0, 0, 0));
        vecs.push_back(mk("over_a2",   0, 2, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 1, 0));
        vecs.push_back(mk("rst1",      1, 0, 0, 0, 0, 0, 0, 0, 0, 32, 32, 33, 0, 0));
        vecs.push_back(mk("ck_a1_t2",  0, 1, 1, 2, 0, 0, 0, 0, 0, 31, 33, 34, 0, 0));
        vecs.push_back(mk("ck_a2_a",   0, 2, 0, 0, 0, 0, 0, 0, 0, 29, 35, 36, 0, 0));
        vecs.push_back(mk("ck_a2_b",   0, 2, 0, 0, 0, 0, 0, 0, 0, 27, 37, 38, 0, 0));
        vecs.push_back(mk("sd_t2",     0, 0, 0, 0, 1, 2, 0, 0, 0, 31, 33, 34, 0, 0));
        vecs.push_back(mk("sf_a2",     0, 2, 0, 0, 0, 0, 0, 0, 0, 29, 35, 36, 0, 0));
        vecs.push_back(mk("sf_ck_t1",  0, 1, 1, 1, 0, 0, 0, 0, 0, 28, 36, 37, 0, 0));
        vecs.push_back(mk("sf_a2_a",   0, 2, 0, 0, 0, 0, 0, 0, 0, 26, 38, 39, 0, 0));
        vecs.push_back(mk("sf_a2_b",   0, 2, 0, 0, 0, 0, 0, 0, 0, 24, 40, 41, 0, 0));
        vecs.push_back(mk("sd_t1_free",0, 2, 0, 0, 1, 1, 2, 0, 3, 29, 36, 37, 0, 0));
        for (int k = 0; k < 13; k++)
            vecs.push_back(mk("to_old_tail", 0, 2, 0, 0, 0, 0, 0, 0, 0, 27 - 2*k, 38 + 2*k, 39 + 2*k, 0, 0));
        vecs.push_back(mk("old_tail_3", 0, 2, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

        // Wrap: alloc 2 / free 2 per cycle, freeing the oldest mapped pregs.
        do_reset("rst_wrap");
        mq.delete(); inuse.delete();
        for (int i = 0; i < 32; i++) begin
            mq.push_back(32 + i);
            inuse.push_back(i);
        end
        for (int c = 0; c < 80; c++) begin
            a1 = mq.pop_front(); a2 = mq.pop_front();
            r1 = inuse.pop_front(); r2 = inuse.pop_front();
            check("wrap.preg1_pre", int'(preg1), a1);
            check("wrap.preg2_pre", int'(preg2), a2);
            mq.push_back(r1); mq.push_back(r2);
            inuse.push_back(a1); inuse.push_back(a2);
            step(mk("wrap", 0, 2, 0, 0, 0, 0, 3, r1, r2, 32, mq[0], mq[1], 0, 0));
        end

        // Overflow: fill to 64, one extra free errors; then mid-sequence reset.
        do_reset("rst_ovf");
        for (int i = 0; i < 16; i++)
            step(mk("fill", 0, 0, 0, 0, 0, 0, 3, 2*i, 2*i + 1, 34 + 2*i, 32, 33, 0, 0));
        step(mk("ovf_free",  0, 0, 0, 0, 0, 0, 1, 5, 0, 64, 32, 33, 0, 1));
        step(mk("ovf_idle",  0, 0, 0, 0, 0, 0, 0, 0, 0, 64, 32, 33, 0, 0));
        step(mk("full_a2",   0, 2, 0, 0, 0, 0, 0, 0, 0, 62, 34, 35, 0, 0));
        step(mk("full_ck2",  0, 2, 1, 2, 0, 0, 0, 0, 0, 60, 36, 37, 0, 0));
        step(mk("full_mix",  0, 1, 0, 0, 0, 0, 1, 40, 0, 60, 37, 38, 0, 0));
        do_reset("rst_mid");
        step(mk("post_a2",   0, 2, 0, 0, 0, 0, 0, 0, 0, 30, 34, 35, 0, 0));
        step(mk("post_sd2",  0, 0, 0, 0, 1, 2, 0, 0, 0, 32, 32, 33, 0, 0));

        check("sb_empty", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
